// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the parametrised UART transmitter
// Contents:
//   PAR_NONE/PAR_EVEN/PAR_ODD : parity_mode encodings (3 behaves as none)
//   tx_state_e                : transmitter FSM states
//   BAUD_TABLE                : baud rate selected by baud_select 0..7
//   baud_div()                : rounded clock divisor for a 16x oversample tick
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2
   } tx_state_e;

   localparam int unsigned BAUD_TABLE [8] = '{300, 1200, 4800, 9600,
                                              19200, 38400, 57600, 115200};

   // round(clk_hz / (16 * baud)) using integer arithmetic
   function automatic int unsigned baud_div(input int unsigned clk_hz,
                                            input int unsigned baud);
      return (clk_hz + 8 * baud) / (16 * baud);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous write FIFO feeding the UART transmitter
// Ports:
//   clk, reset     : clock, synchronous active-low reset
//   push_i, wdata_i: write strobe and data
//   pop_i          : read strobe (rdata_o is valid combinationally while level_o != 0)
//   rdata_o        : head-of-queue word
//   full_o         : DEPTH words stored
//   level_o        : occupancy 0..DEPTH
//   ovf_o          : one-cycle pulse after a push was dropped
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [DATA_BITS-1:0]       wdata_i,
   input  logic                       pop_i,
   output logic [DATA_BITS-1:0]       rdata_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       ovf_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW:0]          level_q, level_d;
   logic                 ovf_q, ovf_d;
   logic                 push_ok, pop_ok;

   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign level_o = level_q;
   assign ovf_o   = ovf_q;
   assign rdata_o = mem[rd_ptr_q];

   // A pop in the same cycle frees the slot, so a push while full still lands.
   assign pop_ok  = pop_i && (level_q != '0);
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = push_i && !push_ok;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - FIFO-buffered UART transmitter with runtime parity/stop/baud
// Ports:
//   clk, reset       : clock, synchronous active-low reset
//   Tx_DATA, Tx_WR   : word and one-cycle write strobe into the FIFO
//   Tx_EN            : allows a new frame to start
//   baud_select      : 300..115200 baud, latched per frame
//   parity_mode      : none/even/odd, latched per frame
//   two_stop         : one or two stop bits, latched per frame
//   TxD              : serial line, idle high
//   Tx_BUSY          : frame in progress or words queued
//   Tx_FULL, Tx_LEVEL: FIFO full flag and occupancy
//   Tx_OVF           : one-cycle pulse after a dropped write
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int          DATA_BITS = 8,
   parameter int          DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_BITS-1:0]     Tx_DATA,
   input  logic                     Tx_WR,
   input  logic                     Tx_EN,
   input  logic [2:0]               baud_select,
   input  logic [1:0]               parity_mode,
   input  logic                     two_stop,
   output logic                     TxD,
   output logic                     Tx_BUSY,
   output logic                     Tx_FULL,
   output logic [$clog2(DEPTH):0]   Tx_LEVEL,
   output logic                     Tx_OVF
);

   localparam int unsigned DIV_MAX = baud_div(CLK_HZ, BAUD_TABLE[0]);
   localparam int          DIV_W   = $clog2(DIV_MAX + 1);
   localparam int          BC_W    = $clog2(DATA_BITS);

   logic [DIV_W-1:0] div_tab [8];
   for (genvar g = 0; g < 8; g++) begin : g_div
      assign div_tab[g] = DIV_W'(baud_div(CLK_HZ, BAUD_TABLE[g]));
   end

   tx_state_e            state_q, state_d;
   logic [DIV_W-1:0]     tick_cnt_q, tick_cnt_d;
   logic [3:0]           os_cnt_q, os_cnt_d;
   logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic                 par_en_q, par_en_d;
   logic                 par_bit_q, par_bit_d;
   logic                 two_stop_q, two_stop_d;

   logic                 pop;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic                 tick, bit_end;

   uart_tx_fifo #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (Tx_WR),
      .wdata_i (Tx_DATA),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (Tx_FULL),
      .level_o (Tx_LEVEL),
      .ovf_o   (Tx_OVF)
   );

   assign fifo_empty = (Tx_LEVEL == '0);
   assign Tx_BUSY    = (state_q != ST_IDLE) || !fifo_empty;

   // One oversample tick every div_q cycles; a bit lasts 16 ticks.
   assign tick    = (state_q != ST_IDLE) && (tick_cnt_q == div_q - DIV_W'(1));
   assign bit_end = tick && (os_cnt_q == 4'd15);

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      os_cnt_d   = os_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      div_d      = div_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      two_stop_d = two_stop_q;
      pop        = 1'b0;

      if (state_q != ST_IDLE) begin
         if (tick) begin
            tick_cnt_d = '0;
            os_cnt_d   = os_cnt_q + 4'd1;
         end else begin
            tick_cnt_d = tick_cnt_q + DIV_W'(1);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (Tx_EN && !fifo_empty) begin
               // Frame configuration is captured here and held for the whole frame.
               pop        = 1'b1;
               shift_d    = fifo_rdata;
               div_d      = div_tab[baud_select];
               two_stop_d = two_stop;
               tick_cnt_d = '0;
               os_cnt_d   = '0;
               bit_cnt_d  = '0;
               case (parity_mode)
                  PAR_EVEN: begin par_en_d = 1'b1; par_bit_d = ^fifo_rdata;  end
                  PAR_ODD:  begin par_en_d = 1'b1; par_bit_d = ~^fifo_rdata; end
                  PAR_NONE: begin par_en_d = 1'b0; par_bit_d = 1'b0;         end
                  default:  begin par_en_d = 1'b0; par_bit_d = 1'b0;         end
               endcase
               state_d    = ST_START;
            end
         end
         ST_START: if (bit_end) state_d = ST_DATA;
         ST_DATA: begin
            if (bit_end) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + BC_W'(1);
               if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? ST_PARITY : ST_STOP1;
               end
            end
         end
         ST_PARITY: if (bit_end) state_d = ST_STOP1;
         ST_STOP1:  if (bit_end) state_d = two_stop_q ? ST_STOP2 : ST_IDLE;
         ST_STOP2:  if (bit_end) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      TxD = 1'b1;
      case (state_q)
         ST_START:  TxD = 1'b0;
         ST_DATA:   TxD = shift_q[0];
         ST_PARITY: TxD = par_bit_q;
         default:   TxD = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         os_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         div_q      <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         os_cnt_q   <= os_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         div_q      <= div_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         two_stop_q <= two_stop_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed self-checking bench for uart_tx_param
// Instances: u_dut (8 data bits, DEPTH 4) and u_dut5 (5 data bits, DEPTH 4)
module tb_uart_tx_param;

   localparam int BP7 = 432;   // 115200 baud bit period at 50 MHz
   localparam int BP6 = 864;   // 57600 baud bit period at 50 MHz

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] Tx_DATA = '0;
   logic       Tx_WR = 1'b0;
   logic       Tx_EN = 1'b0;
   logic [2:0] baud_select = 3'd7;
   logic [1:0] parity_mode = 2'd0;
   logic       two_stop = 1'b0;
   logic       TxD, Tx_BUSY, Tx_FULL, Tx_OVF;
   logic [2:0] Tx_LEVEL;

   logic [4:0] Tx_DATA5 = '0;
   logic       Tx_WR5 = 1'b0;
   logic       TxD5, Tx_BUSY5, Tx_FULL5, Tx_OVF5;
   logic [2:0] Tx_LEVEL5;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_param #(.CLK_HZ(50_000_000), .DATA_BITS(8), .DEPTH(4)) u_dut (
      .clk(clk), .reset(reset), .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN),
      .baud_select(baud_select), .parity_mode(parity_mode), .two_stop(two_stop),
      .TxD(TxD), .Tx_BUSY(Tx_BUSY), .Tx_FULL(Tx_FULL), .Tx_LEVEL(Tx_LEVEL), .Tx_OVF(Tx_OVF)
   );

   uart_tx_param #(.CLK_HZ(50_000_000), .DATA_BITS(5), .DEPTH(4)) u_dut5 (
      .clk(clk), .reset(reset), .Tx_DATA(Tx_DATA5), .Tx_WR(Tx_WR5), .Tx_EN(Tx_EN),
      .baud_select(baud_select), .parity_mode(parity_mode), .two_stop(two_stop),
      .TxD(TxD5), .Tx_BUSY(Tx_BUSY5), .Tx_FULL(Tx_FULL5), .Tx_LEVEL(Tx_LEVEL5), .Tx_OVF(Tx_OVF5)
   );

   task automatic skip(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_low(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (TxD === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Caller is at frame offset start_off (offset 0 = first start-bit cycle).
   // Samples the middle of each bit; returns on the last cycle of the frame.
   task automatic sample_frame(input bit use5, input int bp, input int nbits,
                               input int start_off, output logic [15:0] bits);
      int pos;
      pos  = start_off;
      bits = '0;
      for (int k = 0; k < nbits; k++) begin
         skip(k * bp + bp / 2 - pos);
         pos = k * bp + bp / 2;
         bits[k] = use5 ? TxD5 : TxD;
      end
      skip(nbits * bp - 1 - pos);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      skip(3);
      checks++; if (TxD !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", TxD); end
      checks++; if (Tx_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Tx_BUSY); end
      checks++; if (Tx_FULL !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", Tx_FULL); end
      checks++; if (Tx_LEVEL !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", Tx_LEVEL); end
      checks++; if (Tx_OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", Tx_OVF); end
      reset = 1'b1;
      skip(2);
   endtask

   task automatic test_8n1;
      logic [15:0] bits;
      baud_select = 3'd7; parity_mode = 2'd0; two_stop = 1'b0; Tx_EN = 1'b1;
      Tx_DATA = 8'h55; Tx_WR = 1'b1;
      skip(1);
      Tx_WR = 1'b0;
      checks++; if (Tx_LEVEL !== 3'd1) begin errors++; $display("FAIL 8n1_level_push: got %0d expected 1", Tx_LEVEL); end
      checks++; if (TxD !== 1'b1) begin errors++; $display("FAIL 8n1_idle_before_pop: got %b expected 1", TxD); end
      skip(1);
      checks++; if (TxD !== 1'b0) begin errors++; $display("FAIL 8n1_start_latency: got %b expected 0", TxD); end
      checks++; if (Tx_LEVEL !== 3'd0) begin errors++; $display("FAIL 8n1_level_pop: got %0d expected 0", Tx_LEVEL); end
      sample_frame(1'b0, BP7, 10, 0, bits);
      checks++; if (bits[9:0] !== 10'h2AA) begin errors++; $display("FAIL 8n1_frame: got %h expected 2aa", bits[9:0]); end
      checks++; if (Tx_BUSY !== 1'b1) begin errors++; $display("FAIL 8n1_busy_last: got %b expected 1", Tx_BUSY); end
      skip(1);
      checks++; if (Tx_BUSY !== 1'b0) begin errors++; $display("FAIL 8n1_busy_end: got %b expected 0", Tx_BUSY); end
      checks++; if (TxD !== 1'b1) begin errors++; $display("FAIL 8n1_idle_after: got %b expected 1", TxD); end
   endtask

   task automatic test_parity;
      logic [15:0] bits;
      bit ok;
      for (int m = 0; m < 2; m++) begin
         parity_mode = (m == 0) ? 2'd1 : 2'd2;
         two_stop = 1'b1; Tx_EN = 1'b1;
         Tx_DATA = 8'h07; Tx_WR = 1'b1;
         skip(1);
         Tx_WR = 1'b0;
         wait_low(4, ok);
         checks++; if (!ok) begin errors++; $display("FAIL parity_start_timeout: mode %0d no start bit", m); end
         sample_frame(1'b0, BP7, 12, 0, bits);
         if (m == 0) begin
            checks++; if (bits[11:0] !== 12'hE0E) begin errors++; $display("FAIL even_2stop_frame: got %h expected e0e", bits[11:0]); end
         end else begin
            checks++; if (bits[11:0] !== 12'hC0E) begin errors++; $display("FAIL odd_2stop_frame: got %h expected c0e", bits[11:0]); end
         end
         checks++; if (Tx_BUSY !== 1'b1) begin errors++; $display("FAIL parity_busy_last: mode %0d got %b expected 1", m, Tx_BUSY); end
         skip(1);
         checks++; if (Tx_BUSY !== 1'b0) begin errors++; $display("FAIL parity_frame_len: mode %0d busy %b expected 0", m, Tx_BUSY); end
      end
      parity_mode = 2'd0; two_stop = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [7:0] words [5];
      logic [15:0] bits;
      logic [9:0] exp_frame;
      bit ok;
      int lows;
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
      Tx_EN = 1'b0;
      for (int i = 0; i < 5; i++) begin
         Tx_DATA = words[i]; Tx_WR = 1'b1;
         skip(1);
         if (i == 3) begin
            checks++; if (Tx_FULL !== 1'b1 || Tx_LEVEL !== 3'd4) begin errors++; $display("FAIL fifo_full: full %b level %0d expected 1/4", Tx_FULL, Tx_LEVEL); end
            checks++; if (Tx_OVF !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", Tx_OVF); end
         end
      end
      Tx_WR = 1'b0;
      checks++; if (Tx_OVF !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", Tx_OVF); end
      checks++; if (Tx_LEVEL !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", Tx_LEVEL); end
      skip(1);
      checks++; if (Tx_OVF !== 1'b0) begin errors++; $display("FAIL ovf_single: got %b expected 0", Tx_OVF); end
      Tx_EN = 1'b1;
      wait_low(4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_start_timeout: no start bit"); end
      for (int f = 0; f < 4; f++) begin
         sample_frame(1'b0, BP7, 10, 0, bits);
         exp_frame = {1'b1, words[f], 1'b0};
         checks++; if (bits[9:0] !== exp_frame) begin errors++; $display("FAIL b2b_frame%0d: got %h expected %h", f, bits[9:0], exp_frame); end
         skip(1);
         checks++; if (TxD !== 1'b1) begin errors++; $display("FAIL b2b_gap%0d: got %b expected 1", f, TxD); end
         if (f < 3) begin
            skip(1);
            checks++; if (TxD !== 1'b0) begin errors++; $display("FAIL b2b_restart%0d: got %b expected 0", f, TxD); end
         end
      end
      checks++; if (Tx_BUSY !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", Tx_BUSY); end
      lows = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (TxD !== 1'b1) lows++;
      end
      checks++; if (lows !== 0) begin errors++; $display("FAIL b2b_extra_frame: got %0d low cycles expected 0", lows); end
   endtask

   task automatic test_baud_change;
      logic [15:0] bits;
      Tx_EN = 1'b1; baud_select = 3'd7;
      Tx_DATA = 8'hA5; Tx_WR = 1'b1;
      skip(1);
      Tx_DATA = 8'h3C;
      skip(1);
      Tx_WR = 1'b0;
      checks++; if (TxD !== 1'b0 || Tx_LEVEL !== 3'd1) begin errors++; $display("FAIL baud_setup: txd %b level %0d expected 0/1", TxD, Tx_LEVEL); end
      skip(100);
      baud_select = 3'd6;
      sample_frame(1'b0, BP7, 10, 100, bits);
      checks++; if (bits[9:0] !== 10'h34A) begin errors++; $display("FAIL baud_frame1: got %h expected 34a", bits[9:0]); end
      skip(1);
      checks++; if (TxD !== 1'b1) begin errors++; $display("FAIL baud_frame1_len: got %b expected 1", TxD); end
      skip(1);
      checks++; if (TxD !== 1'b0) begin errors++; $display("FAIL baud_frame2_start: got %b expected 0", TxD); end
      sample_frame(1'b0, BP6, 10, 0, bits);
      checks++; if (bits[9:0] !== 10'h278) begin errors++; $display("FAIL baud_frame2: got %h expected 278", bits[9:0]); end
      checks++; if (Tx_BUSY !== 1'b1) begin errors++; $display("FAIL baud_frame2_busy: got %b expected 1", Tx_BUSY); end
      skip(1);
      checks++; if (Tx_BUSY !== 1'b0) begin errors++; $display("FAIL baud_frame2_len: got %b expected 0", Tx_BUSY); end
      baud_select = 3'd7;
   endtask

   task automatic test_reset_mid_frame;
      int lows;
      Tx_EN = 1'b1;
      Tx_DATA = 8'h81; Tx_WR = 1'b1;
      skip(1);
      Tx_DATA = 8'h42;
      skip(1);
      Tx_DATA = 8'h99;
      skip(1);
      Tx_WR = 1'b0;
      checks++; if (Tx_LEVEL !== 3'd2 || TxD !== 1'b0) begin errors++; $display("FAIL rst_setup: level %0d txd %b expected 2/0", Tx_LEVEL, TxD); end
      skip(3 * BP7);
      reset = 1'b0;
      skip(1);
      checks++; if (TxD !== 1'b1) begin errors++; $display("FAIL rst_mid_txd: got %b expected 1", TxD); end
      checks++; if (Tx_LEVEL !== 3'd0) begin errors++; $display("FAIL rst_mid_level: got %0d expected 0", Tx_LEVEL); end
      checks++; if (Tx_BUSY !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", Tx_BUSY); end
      reset = 1'b1;
      lows = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (TxD !== 1'b1) lows++;
      end
      checks++; if (lows !== 0) begin errors++; $display("FAIL rst_no_frames: got %0d low cycles expected 0", lows); end
   endtask

   task automatic test_5n1;
      logic [15:0] bits;
      Tx_EN = 1'b1; baud_select = 3'd7; parity_mode = 2'd0; two_stop = 1'b0;
      Tx_DATA5 = 5'h1F; Tx_WR5 = 1'b1;
      skip(1);
      Tx_WR5 = 1'b0;
      checks++; if (Tx_LEVEL5 !== 3'd1) begin errors++; $display("FAIL 5n1_level: got %0d expected 1", Tx_LEVEL5); end
      skip(1);
      checks++; if (TxD5 !== 1'b0) begin errors++; $display("FAIL 5n1_start: got %b expected 0", TxD5); end
      sample_frame(1'b1, BP7, 7, 0, bits);
      checks++; if (bits[6:0] !== 7'h7E) begin errors++; $display("FAIL 5n1_frame: got %h expected 7e", bits[6:0]); end
      checks++; if (Tx_BUSY5 !== 1'b1) begin errors++; $display("FAIL 5n1_busy_last: got %b expected 1", Tx_BUSY5); end
      skip(1);
      checks++; if (Tx_BUSY5 !== 1'b0) begin errors++; $display("FAIL 5n1_frame_len: got %b expected 0", Tx_BUSY5); end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_baud_change();
      test_reset_mid_frame();
      test_5n1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
